// File: rtl/psw_seq_pkg.sv
// Shared types and sizing helpers for the power-switch sequencer.
package psw_seq_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  function automatic int psw_ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int psw_timer_w(input int step_cyc);
    return $clog2(step_cyc + 1);
  endfunction

endpackage

// File: rtl/psw_step_timer.sv
// Loadable down-counter: load wins over enable, counting stops at zero.
module psw_step_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/psw_seq_array.sv
// Staggered power-switch sequencer with output isolation clamp.
// Build option: PSW_SEQ_FAST_OFF_EN drops all switches in one edge on power-down.
module psw_seq_array
  import psw_seq_pkg::*;
#(
  parameter int NUM_SW   = 8,
  parameter int GRP_SIZE = 2,
  parameter int STEP_CYC = 4,
  parameter int DATA_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_on,
  output logic [NUM_SW-1:0] sw_en,
  output logic              pwr_good,
  output logic              busy,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output state_t            o_dbg_state
);

  localparam int NUM_GRP = psw_ceil_div(NUM_SW, GRP_SIZE);
  localparam int NW      = $clog2(NUM_GRP + 1);
  localparam int TW      = psw_timer_w(STEP_CYC);

  localparam logic [NW-1:0] NG_L   = NW'(NUM_GRP);
  localparam logic [NW-1:0] ONE_L  = NW'(1);
  localparam logic [TW-1:0] RELOAD = TW'(STEP_CYC - 1);

  state_t            r_state, w_state_nxt;
  logic [NW-1:0]     r_n_on, w_n_on_nxt;
  logic [NUM_SW-1:0] r_sw_en, w_sw_en_nxt;
  logic              r_pwr_good;
  logic              w_load, w_zero, w_busy;

  assign w_busy = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);

  psw_step_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (RELOAD),
    .i_en       (w_busy),
    .o_zero     (w_zero)
  );

  // A direction reversal only reloads the timer; n_on moves at the next step edge.
  always_comb begin
    w_state_nxt = r_state;
    w_n_on_nxt  = r_n_on;
    w_load      = 1'b0;
    unique case (r_state)
      ST_OFF: begin
        if (req_on) begin
          w_state_nxt = ST_RAMP_UP;
          w_n_on_nxt  = ONE_L;
          w_load      = 1'b1;
        end
      end
      ST_RAMP_UP: begin
        if (!req_on) begin
`ifdef PSW_SEQ_FAST_OFF_EN
          w_state_nxt = ST_OFF;
          w_n_on_nxt  = '0;
`else
          w_state_nxt = ST_RAMP_DOWN;
          w_load      = 1'b1;
`endif
        end else if (w_zero) begin
          if (r_n_on < NG_L) begin
            w_n_on_nxt = r_n_on + ONE_L;
            w_load     = 1'b1;
          end else begin
            w_state_nxt = ST_ON;
          end
        end
      end
      ST_ON: begin
        if (!req_on) begin
`ifdef PSW_SEQ_FAST_OFF_EN
          w_state_nxt = ST_OFF;
          w_n_on_nxt  = '0;
`else
          if (NUM_GRP == 1) begin
            w_state_nxt = ST_OFF;
            w_n_on_nxt  = '0;
          end else begin
            w_state_nxt = ST_RAMP_DOWN;
            w_n_on_nxt  = r_n_on - ONE_L;
            w_load      = 1'b1;
          end
`endif
        end
      end
      ST_RAMP_DOWN: begin
`ifdef PSW_SEQ_FAST_OFF_EN
        w_state_nxt = ST_OFF;
        w_n_on_nxt  = '0;
`else
        if (req_on) begin
          w_state_nxt = ST_RAMP_UP;
          w_load      = 1'b1;
        end else if (w_zero) begin
          w_n_on_nxt = r_n_on - ONE_L;
          w_load     = 1'b1;
          if (r_n_on == ONE_L) w_state_nxt = ST_OFF;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_n_on_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    w_sw_en_nxt = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      w_sw_en_nxt[i] = ((i / GRP_SIZE) < int'(w_n_on_nxt));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_n_on     <= '0;
      r_sw_en    <= '0;
      r_pwr_good <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_n_on     <= w_n_on_nxt;
      r_sw_en    <= w_sw_en_nxt;
      r_pwr_good <= (w_state_nxt == ST_ON);
    end
  end

  assign sw_en       = r_sw_en;
  assign pwr_good    = r_pwr_good;
  assign busy        = w_busy;
  assign out         = in & {DATA_W{r_pwr_good}};
  assign o_dbg_state = r_state;

endmodule
